// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM encoding, byte-enable patterns and timeout default for the memory port.
package mem_pkg;
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  localparam logic [3:0] BE_WORD = 4'hF;
  localparam logic [3:0] BE_HALF_LO = 4'h3;
  localparam logic [3:0] BE_HALF_HI = 4'hC;
  localparam int TIMEOUT_CYCLES_DEFAULT = 255;
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: req/ack memory bus between the access unit (master) and memory (slave).
interface mem_access_unit_if;
  logic bus_req;
  logic bus_we;
  logic [29:0] bus_addr;
  logic [3:0] bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic bus_ack;
  logic bus_err;
  modport master (output bus_req, bus_we, bus_addr, bus_be, bus_wdata, bus_err, input bus_rdata, bus_ack);
  modport slave (input bus_req, bus_we, bus_addr, bus_be, bus_wdata, bus_err, output bus_rdata, bus_ack);
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational store lane steering and half-word load extraction with sign extension.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic        stHalf,
  input  logic        stAddr1,
  input  logic [31:0] stWdata,
  output logic [3:0]  be,
  output logic [31:0] busWdata,
  input  logic        ldHalf,
  input  logic        ldAddr1,
  input  logic [31:0] busRdata,
  output logic [31:0] ldData
);
  logic [15:0] half;
  always_comb begin
    be = !stHalf ? BE_WORD : stAddr1 ? BE_HALF_HI : BE_HALF_LO;
    busWdata = stHalf ? {2{stWdata[15:0]}} : stWdata;
    half = ldAddr1 ? busRdata[31:16] : busRdata[15:0];
    ldData = ldHalf ? {{16{half[15]}}, half} : busRdata;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: multicycle memory port, IDLE->REQ->DONE, one mem_ok pulse per access.
// Optional bus timeout enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit
  import mem_pkg::*;
`ifdef MEM_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
)
`endif
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        save_half,
  input  logic        load_half,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_ok,
  output logic [31:0] rdata,
  mem_access_unit_if.master bus
);
  state_t state, nextState;
  logic start, ack, timeout, half, addr1, reqHalf;
  logic [3:0] beNext;
  logic [31:0] stData, ldData;
  // write wins when both strobes arrive together, so its size qualifier is used
  assign reqHalf = mem_write ? save_half : load_half;
  mem_lane_align align (
    .stHalf(reqHalf), .stAddr1(addr[1]), .stWdata(wdata), .be(beNext), .busWdata(stData),
    .ldHalf(half), .ldAddr1(addr1), .busRdata(bus.bus_rdata), .ldData(ldData)
  );
`ifdef MEM_TIMEOUT_EN
  logic [7:0] waitCnt;
  logic err;
  assign timeout = state == REQ && !bus.bus_ack && waitCnt == 8'(TIMEOUT_CYCLES - 1);
  assign bus.bus_err = err;
  always_ff @(posedge clk) begin
    if (rst) begin
      waitCnt <= '0;
      err <= 1'b0;
    end else begin
      waitCnt <= start ? 8'd0 : state == REQ ? waitCnt + 8'd1 : waitCnt;
      err <= timeout;
    end
  end
`else
  assign timeout = 1'b0;
  assign bus.bus_err = 1'b0;
`endif
  always_comb begin
    start = state == IDLE && (mem_read || mem_write);
    ack = state == REQ && bus.bus_ack;
    nextState = start ? REQ : (ack || timeout) ? DONE : state == DONE ? IDLE : state;
  end
  assign mem_ok = state == DONE;
  assign bus.bus_req = state == REQ;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus.bus_we <= 1'b0;
      bus.bus_addr <= '0;
      bus.bus_be <= 4'h0;
      bus.bus_wdata <= '0;
      rdata <= '0;
      half <= 1'b0;
      addr1 <= 1'b0;
    end else begin
      state <= nextState;
      if (start) begin
        bus.bus_we <= mem_write;
        bus.bus_addr <= addr[31:2];
        bus.bus_be <= beNext;
        bus.bus_wdata <= stData;
        half <= reqHalf;
        addr1 <= addr[1];
      end
      if (ack && !bus.bus_we) rdata <= ldData;
      else if (timeout && !bus.bus_we) rdata <= '0;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of the memory port; timeout case built when MEM_TIMEOUT_EN is defined.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_read = 1'b0, mem_write = 1'b0, save_half = 1'b0, load_half = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic mem_ok;
  logic [31:0] rdata;
  int passed = 0, failed = 0, total = 0;
  int pulses, lat, cyc;
  logic sReq, sWe, sErr;
  logic [3:0] sBe;
  logic [29:0] sAddr;
  logic [31:0] sWdata;
  mem_access_unit_if bus ();
  always #5 clk = ~clk;
`ifdef MEM_TIMEOUT_EN
  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
`else
  mem_access_unit dut (
`endif
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .save_half(save_half), .load_half(load_half), .addr(addr), .wdata(wdata),
    .mem_ok(mem_ok), .rdata(rdata), .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (mem_ok) begin
      pulses++;
      if (lat < 0) begin
        lat = cyc;
        sErr = bus.bus_err;
      end
    end
  endtask

  task automatic access(input logic rd, wr, sh, lh, input logic [31:0] a, wd, input int waits, input logic [31:0] rdat);
    pulses = 0; lat = -1; cyc = 0; sErr = 1'bx;
    mem_read = rd; mem_write = wr; save_half = sh; load_half = lh; addr = a; wdata = wd;
    tick();
    mem_read = 0; mem_write = 0; save_half = 0; load_half = 0;
    sReq = bus.bus_req; sWe = bus.bus_we; sBe = bus.bus_be; sAddr = bus.bus_addr; sWdata = bus.bus_wdata;
    repeat (waits) tick();
    bus.bus_ack = 1'b1; bus.bus_rdata = rdat;
    tick();
    bus.bus_ack = 1'b0; bus.bus_rdata = 32'h0;
    tick();
    tick();
  endtask

  initial begin
    bus.bus_ack = 1'b0;
    bus.bus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_ok", 32'(mem_ok), 32'h0);
    chk("rst_bus_req", 32'(bus.bus_req), 32'h0);
    chk("rst_bus_be", 32'(bus.bus_be), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_bus_addr", 32'(bus.bus_addr), 32'h0);
    chk("rst_bus_err", 32'(bus.bus_err), 32'h0);
    rst = 1'b0;
    tick();

    access(1, 0, 0, 0, 32'h100, 32'h0, 2, 32'hDEADBEEF);
    chk("wrd_req", 32'(sReq), 32'h1);
    chk("wrd_we", 32'(sWe), 32'h0);
    chk("wrd_addr", 32'(sAddr), 32'h40);
    chk("wrd_be", 32'(sBe), 32'hF);
    chk("wrd_pulses", pulses, 1);
    chk("wrd_lat", lat, 4);
    chk("wrd_err", 32'(sErr), 32'h0);
    chk("wrd_rdata", rdata, 32'hDEADBEEF);

    access(0, 1, 1, 0, 32'h102, 32'h1234ABCD, 1, 32'h55555555);
    chk("hst_we", 32'(sWe), 32'h1);
    chk("hst_be", 32'(sBe), 32'hC);
    chk("hst_wdata", sWdata, 32'hABCDABCD);
    chk("hst_pulses", pulses, 1);
    chk("hst_rdata", rdata, 32'hDEADBEEF);

    access(0, 1, 0, 0, 32'h203, 32'hCAFEF00D, 0, 32'h0);
    chk("wst_addr", 32'(sAddr), 32'h80);
    chk("wst_be", 32'(sBe), 32'hF);
    chk("wst_wdata", sWdata, 32'hCAFEF00D);

    access(1, 0, 0, 1, 32'h100, 32'h0, 1, 32'h00008001);
    chk("hld_lo_be", 32'(sBe), 32'h3);
    chk("hld_lo_rdata", rdata, 32'hFFFF8001);
    access(1, 0, 0, 1, 32'h102, 32'h0, 0, 32'h00008001);
    chk("hld_hi_be", 32'(sBe), 32'hC);
    chk("hld_hi_rdata", rdata, 32'h00000000);

    access(1, 0, 0, 0, 32'h10, 32'h0, 0, 32'h12345678);
    chk("zw_lat", lat, 2);
    chk("zw_pulses", pulses, 1);
    chk("zw_rdata", rdata, 32'h12345678);

    access(1, 1, 0, 0, 32'h20, 32'h0BADF00D, 0, 32'h77777777);
    chk("both_we", 32'(sWe), 32'h1);
    chk("both_wdata", sWdata, 32'h0BADF00D);
    chk("both_pulses", pulses, 1);
    chk("both_rdata", rdata, 32'h12345678);

    bus.bus_ack = 1'b1; bus.bus_rdata = 32'hFFFFFFFF;
    pulses = 0; lat = -1; cyc = 0;
    tick();
    tick();
    bus.bus_ack = 1'b0; bus.bus_rdata = 32'h0;
    chk("idle_ack_pulses", pulses, 0);
    chk("idle_ack_rdata", rdata, 32'h12345678);

    mem_read = 1; addr = 32'h300;
    tick();
    mem_read = 0;
    chk("rstreq_req", 32'(bus.bus_req), 32'h1);
    rst = 1'b1;
    pulses = 0;
    tick();
    rst = 1'b0;
    chk("rstreq_drop", 32'(bus.bus_req), 32'h0);
    tick();
    tick();
    chk("rstreq_pulses", pulses, 0);
    access(1, 0, 0, 0, 32'h304, 32'h0, 1, 32'hA5A5A5A5);
    chk("rstreq_next_pulses", pulses, 1);
    chk("rstreq_next_rdata", rdata, 32'hA5A5A5A5);

`ifdef MEM_TIMEOUT_EN
    pulses = 0; lat = -1; cyc = 0; sErr = 1'b0;
    mem_read = 1; addr = 32'h400;
    tick();
    mem_read = 0;
    for (int i = 0; i < 20 && lat < 0; i++) tick();
    chk("to_lat", lat, 5);
    chk("to_err", 32'(sErr), 32'h1);
    chk("to_rdata", rdata, 32'h0);
    tick();
    chk("to_err_clear", 32'(bus.bus_err), 32'h0);
    chk("to_pulses", pulses, 1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
